// File: rtl/ste_pad_pkg.sv
// Shared definitions for the STE enhanced joypad scanner: joy bit map, row wiring table,
// scan FSM states and the select-pattern helper.
package ste_pad_pkg;

  typedef logic [4:0] bit_idx_t;

  localparam int unsigned JOY_W = 21;

  localparam bit_idx_t JOY_R     = 5'd0;
  localparam bit_idx_t JOY_L     = 5'd1;
  localparam bit_idx_t JOY_D     = 5'd2;
  localparam bit_idx_t JOY_U     = 5'd3;
  localparam bit_idx_t JOY_A     = 5'd4;
  localparam bit_idx_t JOY_B     = 5'd5;
  localparam bit_idx_t JOY_C     = 5'd6;
  localparam bit_idx_t JOY_OPT   = 5'd7;
  localparam bit_idx_t JOY_PAUSE = 5'd8;
  localparam bit_idx_t JOY_0     = 5'd9;
  localparam bit_idx_t JOY_STAR  = 5'd10;
  localparam bit_idx_t JOY_HASH  = 5'd11;
  localparam bit_idx_t JOY_1     = 5'd12;
  localparam bit_idx_t JOY_2     = 5'd13;
  localparam bit_idx_t JOY_3     = 5'd14;
  localparam bit_idx_t JOY_4     = 5'd15;
  localparam bit_idx_t JOY_5     = 5'd16;
  localparam bit_idx_t JOY_6     = 5'd17;
  localparam bit_idx_t JOY_7     = 5'd18;
  localparam bit_idx_t JOY_8     = 5'd19;
  localparam bit_idx_t JOY_9     = 5'd20;

  localparam logic [1:0] PAUSE_ROW = 2'd0;

  typedef enum logic [2:0] {
    StIdle,
    StRelease,
    StSettle,
    StSample,
    StGap
  } scan_state_e;

  // col[k] is the joy bit fed by col_n[k] while that row is selected.
  typedef struct packed {
    bit_idx_t [3:0] col;
    bit_idx_t       fire;
  } row_map_t;

  localparam row_map_t ROW_MAP [4] = '{
    '{col: {JOY_R, JOY_L, JOY_D, JOY_U},    fire: JOY_A},
    '{col: {JOY_1, JOY_4, JOY_7, JOY_STAR}, fire: JOY_B},
    '{col: {JOY_2, JOY_5, JOY_8, JOY_HASH}, fire: JOY_C},
    '{col: {JOY_3, JOY_6, JOY_9, JOY_0},    fire: JOY_OPT}
  };

  function automatic logic [3:0] sel_pattern(scan_state_e st, logic [1:0] row);
    if (st == StSettle || st == StSample) begin
      return ~(4'b0001 << row);
    end
    return 4'hF;
  endfunction

endpackage

// File: rtl/ste_joypad_scanner_if.sv
// Physical pad port: active-low selects out, active-low columns and buttons back.
interface ste_joypad_scanner_if;
  logic [3:0] sel_n;
  logic [3:0] col_n;
  logic [1:0] btn_n;

  modport master (output sel_n, input col_n, input btn_n);
  modport slave  (input sel_n, output col_n, output btn_n);
endinterface

// File: rtl/ste_pad_debounce.sv
// Frame-level debounce: joy only follows a frame seen DEBOUNCE times in a row.
module ste_pad_debounce
  import ste_pad_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_done_i,
  input  logic [JOY_W-1:0] frame_i,
  output logic [JOY_W-1:0] joy_o,
  output logic             joy_changed_o
);

  localparam logic [3:0] StableMax = 4'(DEBOUNCE - 1);

  logic [JOY_W-1:0] prev_q, prev_d;
  logic [JOY_W-1:0] joy_q, joy_d;
  logic [3:0]       stable_q, stable_d;
  logic             changed_q, changed_d;

  always_comb begin
    prev_d    = prev_q;
    joy_d     = joy_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (frame_done_i) begin
      prev_d = frame_i;
      if (frame_i != prev_q) begin
        stable_d = '0;
      end else if (stable_q != StableMax) begin
        stable_d = stable_q + 4'd1;
      end
      if (stable_d == StableMax && frame_i != joy_q) begin
        joy_d     = frame_i;
        changed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= '0;
      joy_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      joy_q     <= joy_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign joy_o         = joy_q;
  assign joy_changed_o = changed_q;

endmodule

// File: rtl/ste_joypad_scanner.sv
// Host-side scanner for the STE enhanced joypad port: walks the four select rows,
// samples columns/buttons into a shadow frame and hands each full frame to the debouncer.
module ste_joypad_scanner
  import ste_pad_pkg::*;
#(
  parameter int unsigned SETTLE_TICKS = 8,
  parameter int unsigned FRAME_GAP    = 64,
  parameter int unsigned DEBOUNCE     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 enable,
  ste_joypad_scanner_if.master pad,
  output logic [JOY_W-1:0]     joy,
  output logic                 joy_valid,
  output logic                 joy_changed,
  output logic                 busy
);

  localparam logic [15:0] SettleLast = 16'(SETTLE_TICKS - 1);
  // A zero gap still spends one tick in StGap.
  localparam logic [15:0] GapLast    = (FRAME_GAP == 0) ? 16'd0 : 16'(FRAME_GAP - 1);

  scan_state_e      state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [JOY_W-1:0] shadow_q, shadow_d;
  logic [3:0]       sel_n_q, sel_n_d;
  logic             valid_q;
  logic             frame_done;
  logic             in_frame;

  assign in_frame = (state_q == StRelease) || (state_q == StSettle) || (state_q == StSample);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    frame_done = 1'b0;
    if (ce) begin
      if (in_frame && !enable) begin
        // Abort: partial frame dropped, debouncer never sees it.
        state_d  = StIdle;
        row_d    = '0;
        cnt_d    = '0;
        shadow_d = '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (enable) begin
              state_d = StRelease;
              row_d   = '0;
            end
          end
          StRelease: begin
            state_d = StSettle;
            cnt_d   = '0;
          end
          StSettle: begin
            if (cnt_q == SettleLast) begin
              state_d = StSample;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          StSample: begin
            for (int c = 0; c < 4; c++) begin
              shadow_d[ROW_MAP[row_q].col[c]] = ~pad.col_n[c];
            end
            shadow_d[ROW_MAP[row_q].fire] = ~pad.btn_n[1];
            if (row_q == PAUSE_ROW) begin
              shadow_d[JOY_PAUSE] = ~pad.btn_n[0];
            end
            if (row_q != 2'd3) begin
              row_d   = row_q + 2'd1;
              state_d = StRelease;
            end else begin
              frame_done = 1'b1;
              state_d    = StGap;
              cnt_d      = '0;
            end
          end
          StGap: begin
            if (cnt_q == GapLast) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
    sel_n_d = sel_pattern(state_d, row_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      row_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      sel_n_q  <= 4'hF;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sel_n_q  <= sel_n_d;
      valid_q  <= frame_done;
    end
  end

  ste_pad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .frame_done_i (frame_done),
    .frame_i      (shadow_d),
    .joy_o        (joy),
    .joy_changed_o(joy_changed)
  );

  assign pad.sel_n = sel_n_q;
  assign joy_valid = valid_q;
  assign busy      = in_frame;

endmodule

// File: tb/tb_ste_joypad_scanner.sv
// Bench for ste_joypad_scanner: loopback pad model, random ce, frame-history debounce model.
module tb_ste_joypad_scanner;

  localparam int unsigned SETTLE = 8;
  localparam int unsigned GAP    = 64;
  localparam int unsigned DEB    = 2;
  localparam int          PERIOD = 4 * (SETTLE + 2) + GAP + 1;

  // Pad wiring: per row, joy bits on col_n[0..3], then the fire-line bit.
  localparam logic [4:0] PadMap [4][5] = '{
    '{5'd3,  5'd2,  5'd1,  5'd0,  5'd4},
    '{5'd10, 5'd18, 5'd15, 5'd12, 5'd5},
    '{5'd11, 5'd19, 5'd16, 5'd13, 5'd6},
    '{5'd9,  5'd20, 5'd17, 5'd14, 5'd7}
  };

  logic        clk = 1'b0;
  logic        reset;
  logic        ce = 1'b0;
  logic        enable;
  logic [20:0] joy;
  logic        joy_valid;
  logic        joy_changed;
  logic        busy;

  logic [20:0] keys;
  logic        force_p0;
  bit          ce_run;

  ste_joypad_scanner_if pad ();

  ste_joypad_scanner #(
    .SETTLE_TICKS(SETTLE),
    .FRAME_GAP   (GAP),
    .DEBOUNCE    (DEB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .enable     (enable),
    .pad        (pad),
    .joy        (joy),
    .joy_valid  (joy_valid),
    .joy_changed(joy_changed),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    ce = ce_run && ($urandom_range(0, 3) != 0);
  end

  // Pad model: a selected row pulls low the lines of every held key on it.
  always_comb begin
    pad.col_n = 4'hF;
    pad.btn_n = 2'b11;
    for (int r = 0; r < 4; r++) begin
      if (pad.sel_n[r] == 1'b0) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[PadMap[r][c]]) pad.col_n[c] = 1'b0;
        end
        if (keys[PadMap[r][4]]) pad.btn_n[1] = 1'b0;
        if ((r == 0 && keys[8]) || (r != 0 && force_p0)) pad.btn_n[0] = 1'b0;
      end
    end
  end

  int          tick_cnt = 0;
  int          valid_cnt = 0;
  int          valid_tick = 0;
  int          sel_viol = 0;
  int          pulse_viol = 0;
  logic [3:0]  last_sel = 4'hF;
  logic        prev_v = 1'b0;
  logic        prev_c = 1'b0;

  always @(negedge clk) begin
    if (joy_valid === 1'b1) begin
      valid_cnt++;
      valid_tick = tick_cnt;
      if (prev_v) pulse_viol++;
    end
    if (joy_changed === 1'b1 && prev_c) pulse_viol++;
    prev_v = (joy_valid === 1'b1);
    prev_c = (joy_changed === 1'b1);
    if ($countones(~pad.sel_n) > 1) sel_viol++;
    if (ce === 1'b1) begin
      if (last_sel != 4'hF && pad.sel_n != 4'hF && pad.sel_n != last_sel) sel_viol++;
      last_sel = pad.sel_n;
      tick_cnt++;
    end
  end

  int          n_checks = 0;
  int          n_pass = 0;
  logic [20:0] hist[$];
  logic [20:0] m_joy;
  int          last_vt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    m_joy = '0;
  endtask

  // joy takes a frame once the last DEB frames (reset counts as a zero frame) agree.
  task automatic model_frame(input logic [20:0] f, output logic [20:0] ej, output bit ec);
    bit same;
    same = 1'b1;
    hist.push_back(f);
    if (hist.size() < int'(DEB)) same = 1'b0;
    else begin
      for (int k = 0; k < int'(DEB); k++) begin
        if (hist[hist.size() - 1 - k] != f) same = 1'b0;
      end
    end
    ec = same && (f != m_joy);
    if (ec) m_joy = f;
    ej = m_joy;
  endtask

  task automatic do_frame(input string tag);
    bit          seen;
    logic [20:0] ej;
    bit          ec;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (joy_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      model_frame(keys, ej, ec);
      chk({tag, "_joy"}, 32'(joy), 32'(ej));
      chk({tag, "_changed"}, 32'(joy_changed), 32'(ec));
      #1;
      if (last_vt >= 0) chk({tag, "_period"}, 32'(valid_tick - last_vt), 32'(PERIOD));
      last_vt = valid_tick;
    end
  endtask

  bit          ok;
  int          vc;
  int          hold;
  logic [20:0] jh;
  logic [3:0]  s0;
  logic [3:0]  first_row;

  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    keys     = '0;
    force_p0 = 1'b0;
    ce_run   = 1'b1;
    last_vt  = -1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_sel_n", 32'(pad.sel_n), 32'hF);
    chk("rst_joy", 32'(joy), 32'd0);
    chk("rst_valid", 32'(joy_valid), 32'd0);
    chk("rst_changed", 32'(joy_changed), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    repeat (50) @(negedge clk);
    #1;
    chk("disabled_busy", 32'(busy), 32'd0);
    chk("disabled_no_valid", 32'(valid_cnt), 32'd0);

    enable = 1'b1;
    for (int i = 0; i < 3; i++) do_frame($sformatf("nokey%0d", i));

    keys = 21'h000118;
    do_frame("uap_f1");
    do_frame("uap_f2");
    chk("uap_joy_const", 32'(joy), 32'h000118);

    keys     = 21'h100080;
    force_p0 = 1'b1;
    do_frame("k9opt_f1");
    do_frame("k9opt_f2");
    chk("k9opt_joy_const", 32'(joy), 32'h100080);
    force_p0 = 1'b0;

    keys = 21'h110080;
    do_frame("glitch_on");
    keys = 21'h100080;
    do_frame("glitch_off1");
    do_frame("glitch_off2");
    chk("glitch_joy_held", 32'(joy), 32'h100080);
    keys = 21'h110080;
    do_frame("key5_f1");
    do_frame("key5_f2");
    chk("key5_bit16", 32'(joy[16]), 32'd1);

    for (int it = 0; it < 8; it++) begin
      keys = 21'($urandom);
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) do_frame($sformatf("rand%0d_%0d", it, h));
    end

    // Drop enable while row 2 is settling.
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (pad.sel_n === 4'b1011) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_row2_seen", 32'(ok), 32'd1);
    vc     = valid_cnt;
    jh     = joy;
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (ce === 1'b1) break;
    end
    @(negedge clk);
    chk("abort_sel_n", 32'(pad.sel_n), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_valid_now", 32'(joy_valid), 32'd0);
    repeat (300) @(negedge clk);
    #1;
    chk("abort_no_valid_later", 32'(valid_cnt), 32'(vc));
    chk("abort_joy_held", 32'(joy), 32'(jh));
    chk("abort_idle_sel_n", 32'(pad.sel_n), 32'hF);

    enable    = 1'b1;
    last_vt   = -1;
    first_row = 4'hF;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pad.sel_n !== 4'hF) begin
        first_row = pad.sel_n;
        break;
      end
    end
    chk("reenable_first_row", 32'(first_row), 32'hE);
    do_frame("reenable");

    keys = 21'h0A5A5A;
    do_frame("prerst_f1");
    do_frame("prerst_f2");
    chk("prerst_joy_const", 32'(joy), 32'h0A5A5A);

    // Freeze mid-frame with ce low, then reset.
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("midframe_busy_seen", 32'(ok), 32'd1);
    ce_run = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    s0 = pad.sel_n;
    repeat (5) @(negedge clk);
    chk("freeze_sel_n", 32'(pad.sel_n), 32'(s0));
    chk("freeze_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_sel_n", 32'(pad.sel_n), 32'hF);
    chk("midrst_joy", 32'(joy), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_changed", 32'(joy_changed), 32'd0);
    reset   = 1'b0;
    model_reset();
    last_vt = -1;
    ce_run  = 1'b1;
    do_frame("postrst_f1");
    do_frame("postrst_f2");

    #1;
    chk("sel_n_protocol", 32'(sel_viol), 32'd0);
    chk("pulse_width", 32'(pulse_viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ste_joypad_scanner.md
Name: ste_joypad_scanner

Overview:
- Host-side initiator for the STE enhanced joypad port: drives active-low select lines (pins 1-4), samples the returned columns (pins 11-14) and buttons (pins 10, 6), and assembles the 21-bit active-high joy vector.
- Bit layout of joy is the team's standard STE pad map: UDLR, A/B/C/Option, Pause, 0/*/#, keypad 1-9.
- Sits between the physical pad port (or a pad emulator in loopback) and the core's input mux.
- Runs from the system clock, qualified by a ce tick.

Parameters:
- SETTLE_TICKS, 8: ce ticks a select row is held before sampling; legal range 1..255.
- FRAME_GAP, 64: ce ticks idle between frames; legal range 0..65535.
- DEBOUNCE, 2: consecutive identical frames required before joy updates; 1 disables debounce; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  scan tick; all FSM and counters advance only when ce=1.
- enable  in  1  scanning permitted.
- sel_n  out  4  select pins 1-4, active-low one-hot (bit k = row k).
- col_n  in  4  pins 11-14, active-low; col_n[0]=U-column, [1]=D-column, [2]=L-column, [3]=R-column; synchronised externally.
- btn_n  in  2  pins 10, 6, active-low; btn_n[1]=fire column, btn_n[0]=Pause.
- joy  out  21  debounced pad state, active-high.
- joy_valid  out  1  one-clk pulse per completed frame.
- joy_changed  out  1  one-clk pulse when joy takes a new value.
- busy  out  1  high while a frame is in progress.

Behaviour:
- Reset values: sel_n=4'hF, joy=0, joy_valid=0, joy_changed=0, busy=0, state IDLE, all counters 0, shadow 0.
- FSM states: IDLE, RELEASE, SETTLE, SAMPLE, GAP.
- IDLE: on ce with enable=1 go to RELEASE, row=0, busy=1.
- RELEASE: sel_n=F for exactly one ce tick, then SETTLE.
- SETTLE: sel_n=~(1<<row); counts SETTLE_TICKS ce ticks, then SAMPLE.
  - sel_n is registered and changes on the clk edge of the transition.
- SAMPLE (one ce tick, sel_n still asserted): capture the inverted inputs into shadow.
  - Row 0: shadow[3]=~col_n[0], [2]=~col_n[1], [1]=~col_n[2], [0]=~col_n[3], [4]=~btn_n[1], [8]=~btn_n[0].
  - Row 1: bits 10, 18, 15, 12 from col_n[0..3]; bit 5 from btn_n[1].
  - Row 2: bits 11, 19, 16, 13 from col_n[0..3]; bit 6 from btn_n[1].
  - Row 3: bits 9, 20, 17, 14 from col_n[0..3]; bit 7 from btn_n[1].
  - btn_n[0] is ignored in rows 1-3.
  - If row<3: row++ and go to RELEASE. Otherwise end frame, then GAP.
- Frame length: 4*(SETTLE_TICKS+2) ce ticks.
- End of frame, same clk:
  - joy_valid=1.
  - If shadow==prev_frame, stable count++ (saturating at DEBOUNCE-1); else stable count=0.
  - prev_frame<=shadow.
  - If stable count reaches DEBOUNCE-1 and shadow!=joy: joy<=shadow and joy_changed=1.
  - With DEBOUNCE=1, joy follows every frame.
- GAP: sel_n=F, busy=0; counts FRAME_GAP ce ticks, then IDLE. FRAME_GAP=0 means GAP lasts one ce tick.
- enable dropped mid-frame: on the next ce, abort to IDLE, sel_n=F, partial shadow discarded, joy held, no pulses.
- enable dropped in GAP: GAP finishes, then the FSM stays in IDLE.
- ce=0: all state, including sel_n, is frozen; pulses still last exactly one clk.
- Reset mid-frame: everything returns to reset values on the next clk regardless of ce.
- sel_n never has more than one bit low, and is all-high for at least one ce tick between rows.

Decomposition:
- Shared package ste_pad_pkg:
  - joy bit-index constants (JOY_R=0 … JOY_9=20).
  - Row-to-bit mapping table: 4 rows × (4 column bits + fire bit).
  - PAUSE_ROW=0.
  - FSM state enum.
- One sub-module, ste_pad_debounce: frame compare, stable counter, and joy/joy_changed update, fed by shadow and a frame_done strobe.

Test Plan:
- Loopback to a pad model with no keys, DEBOUNCE=2: joy stays 0, joy_valid pulses every 4*(8+2)+64+1 ce ticks, joy_changed never pulses.
- Pad holds U+A+Pause (model joy=21'h000118): joy_changed pulses at end of frame 2; joy=21'h000118.
- Pad holds keypad 9 and Option (21'h100080): only the row-3 sample sets bits; joy=21'h100080 after 2 frames; with btn_n[0] forced low in rows 1-3, bit 8 stays 0.
- Glitch: key 5 is present for a single frame only -> joy unchanged, no joy_changed. Key 5 held for 2 frames -> joy bit 16 set.
- enable deasserted during row 2 SETTLE -> sel_n=F on the next ce, state IDLE, no joy_valid. Re-enable -> next frame starts at row 0.
- reset asserted mid-frame with ce=0 -> next clk: sel_n=F, joy=0, busy=0. Assertion throughout the bench: never two sel_n bits low, and always one all-high tick between rows.
